// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch run/pause sequencer: FSM states,
// mode-select decode values, BCD preset constants and a digit clamp helper.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } sw_state_t;

  typedef enum logic [1:0] {
    MODE_UP_ZERO = 2'b00,
    MODE_UP_LOAD = 2'b01,
    MODE_DN_FULL = 2'b10,
    MODE_DN_LOAD = 2'b11
  } sw_mode_t;

  localparam logic [15:0] BCD_ZERO = 16'h0000;
  localparam logic [15:0] BCD_FULL = 16'h9999;

  // Out-of-range BCD digits from the switches saturate at 9.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
    return (digit > 4'd9) ? 4'd9 : digit;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Control bundle between the stopwatch sequencer (master) and the BCD
// counter datapath (slave).
interface stopwatch_ctrl_if;
  logic        cnt_en;
  logic        cnt_up;
  logic        cnt_ld;
  logic [15:0] ld_val;
  logic        term;

  modport master (output cnt_en, output cnt_up, output cnt_ld, output ld_val, input term);
  modport slave  (input cnt_en, input cnt_up, input cnt_ld, input ld_val, output term);
endinterface

// File: rtl/sw_debounce.sv
// Button conditioner: 2-flop synchronizer, optional counter debouncer
// (STOPWATCH_DEBOUNCE_EN), then a registered single-cycle rising-edge pulse.
module sw_debounce #(
  parameter int unsigned DB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);

  logic sync1_reg;
  logic sync2_reg;
  logic level;
  logic level_prev_reg;
  logic pulse_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg      <= 1'b0;
      sync2_reg      <= 1'b0;
      level_prev_reg <= 1'b0;
      pulse_reg      <= 1'b0;
    end else begin
      sync1_reg      <= raw;
      sync2_reg      <= sync1_reg;
      level_prev_reg <= level;
      pulse_reg      <= level & ~level_prev_reg;
    end
  end

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DB_CYCLES + 1);

  logic [CW-1:0] db_cnt_reg;
  logic          db_level_reg;

  // Level only flips after DB_CYCLES consecutive samples disagree with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_reg   <= '0;
      db_level_reg <= 1'b0;
    end else if (sync2_reg == db_level_reg) begin
      db_cnt_reg <= '0;
    end else if (db_cnt_reg == CW'(DB_CYCLES - 1)) begin
      db_cnt_reg   <= '0;
      db_level_reg <= sync2_reg;
    end else begin
      db_cnt_reg <= db_cnt_reg + 1'b1;
    end
  end

  assign level = db_level_reg;
`else
  assign level = sync2_reg;
`endif

  assign pulse = pulse_reg;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause sequencer: button conditioning, IDLE/RUN/PAUSE/DONE FSM,
// tick prescaler and preset decode. Define STOPWATCH_DEBOUNCE_EN to debounce buttons.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 1_000_000,
  parameter int unsigned DB_CYCLES = 500_000
) (
  input  logic                    clk,
  input  logic                    R,
  input  logic                    P,
  input  logic                    clr,
  input  logic [1:0]              sel,
  input  logic [7:0]              load,
  stopwatch_ctrl_if.master        dp,
  output logic [1:0]              cstateDb
);

  localparam int unsigned     PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

  sw_state_t     state_reg, state_next;
  sw_mode_t      sel_reg;
  logic [PW-1:0] presc_reg, presc_next;
  logic          armed_reg;
  logic          cnt_en_reg, cnt_en_next;
  logic          cnt_ld_reg, cnt_ld_next;
  logic [15:0]   ld_val;
  logic [1:0]    btn_raw, btn_pulse;
  logic          p_pulse, c_pulse, ld_req, tick;

  assign btn_raw = {clr, P};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_btn (
        .clk   (clk),
        .rst_n (R),
        .raw   (btn_raw[gi]),
        .pulse (btn_pulse[gi])
      );
    end
  endgenerate

  assign p_pulse = btn_pulse[0];
  assign c_pulse = btn_pulse[1];

  // armed_reg is low only until the first edge after reset, forcing one preset load.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_reg  <= ST_IDLE;
      sel_reg    <= MODE_UP_ZERO;
      presc_reg  <= '0;
      armed_reg  <= 1'b0;
      cnt_en_reg <= 1'b0;
      cnt_ld_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sel_reg    <= sw_mode_t'(sel);
      presc_reg  <= presc_next;
      armed_reg  <= 1'b1;
      cnt_en_reg <= cnt_en_next;
      cnt_ld_reg <= cnt_ld_next;
    end
  end

  always_comb begin
    ld_req     = c_pulse | (sel != sel_reg) | ~armed_reg;
    tick       = (state_reg == ST_RUN) && (presc_reg == PRESC_MAX);
    state_next = state_reg;
    presc_next = presc_reg;
    if (ld_req) begin
      state_next = ST_IDLE;
      presc_next = '0;
    end else begin
      if (state_reg == ST_RUN) begin
        presc_next = tick ? '0 : presc_reg + 1'b1;
      end
      case (state_reg)
        ST_IDLE:  if (p_pulse) state_next = ST_RUN;
        ST_RUN: begin
          if (p_pulse)              state_next = ST_PAUSE;
          else if (tick && dp.term) state_next = ST_DONE;
        end
        ST_PAUSE: if (p_pulse) state_next = ST_RUN;
        default:  state_next = state_reg;
      endcase
    end
  end

  // A tick at terminal count is swallowed so the counter saturates.
  always_comb begin
    cnt_en_next = tick & ~dp.term & ~ld_req;
    cnt_ld_next = ld_req;
    case (sel_reg)
      MODE_UP_ZERO: ld_val = BCD_ZERO;
      MODE_DN_FULL: ld_val = BCD_FULL;
      default:      ld_val = {bcd_clamp(load[7:4]), bcd_clamp(load[3:0]), 8'h00};
    endcase
  end

  assign dp.cnt_en = cnt_en_reg;
  assign dp.cnt_ld = cnt_ld_reg;
  assign dp.cnt_up = ~sel_reg[1];
  assign dp.ld_val = ld_val;
  assign cstateDb  = state_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with TICK_DIV=4, no debounce.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       R, P, clr;
  logic [1:0] sel;
  logic [7:0] load;
  logic [1:0] cstateDb;
  int         n_pass = 0;
  int         n_fail = 0;
  int         n_total = 0;

  stopwatch_ctrl_if sw_if();

  stopwatch_ctrl #(.TICK_DIV(4), .DB_CYCLES(8)) dut (
    .clk      (clk),
    .R        (R),
    .P        (P),
    .clr      (clr),
    .sel      (sel),
    .load     (load),
    .dp       (sw_if),
    .cstateDb (cstateDb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
      $display("check %-14s observed %h expected %h ok", tag, obs, exp);
    end else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_p();
    P = 1'b1;
    cyc(1);
    P = 1'b0;
  endtask

  initial begin
    R = 1'b0; P = 1'b0; clr = 1'b0; sel = 2'b00; load = 8'h00; sw_if.term = 1'b0;
    cyc(2);
    chk("rst_state", 16'(cstateDb), 16'h0);
    chk("rst_en", 16'(sw_if.cnt_en), 16'h0);
    chk("rst_ld", 16'(sw_if.cnt_ld), 16'h0);
    chk("rst_up", 16'(sw_if.cnt_up), 16'h1);
    chk("rst_ldval", sw_if.ld_val, 16'h0000);

    R = 1'b1;
    cyc(1);
    chk("init_ld", 16'(sw_if.cnt_ld), 16'h1);
    chk("init_ldval", sw_if.ld_val, 16'h0000);
    chk("init_en", 16'(sw_if.cnt_en), 16'h0);
    cyc(1);
    chk("init_ld_off", 16'(sw_if.cnt_ld), 16'h0);

    // Start: state moves on the 4th edge after P rises
    press_p();
    cyc(2);
    chk("p_latency", 16'(cstateDb), 16'h0);
    cyc(1);
    chk("run_state", 16'(cstateDb), 16'h1);
    chk("run_up", 16'(sw_if.cnt_up), 16'h1);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("pre_tick", 16'(sw_if.cnt_en), 16'h0);
    end
    cyc(1);
    chk("tick1", 16'(sw_if.cnt_en), 16'h1);
    cyc(1);
    chk("tick1_off", 16'(sw_if.cnt_en), 16'h0);
    cyc(1);
    chk("tick1_gap", 16'(sw_if.cnt_en), 16'h0);
    press_p();
    chk("tick2_pre", 16'(sw_if.cnt_en), 16'h0);
    cyc(1);
    chk("tick2", 16'(sw_if.cnt_en), 16'h1);
    cyc(1);
    chk("still_run", 16'(cstateDb), 16'h1);
    cyc(1);
    chk("pause_state", 16'(cstateDb), 16'h2);
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk("pause_no_tick", 16'(sw_if.cnt_en), 16'h0);
    end
    press_p();
    cyc(2);
    chk("pause_hold", 16'(cstateDb), 16'h2);
    cyc(1);
    chk("resume_state", 16'(cstateDb), 16'h1);
    chk("resume_en0", 16'(sw_if.cnt_en), 16'h0);
    cyc(1);
    chk("resume_en1", 16'(sw_if.cnt_en), 16'h0);
    cyc(1);
    chk("resume_tick", 16'(sw_if.cnt_en), 16'h1);

    // Mode changes force IDLE plus a preset load
    sel = 2'b01; load = 8'h99;
    cyc(1);
    chk("sel01_state", 16'(cstateDb), 16'h0);
    chk("sel01_ld", 16'(sw_if.cnt_ld), 16'h1);
    chk("sel01_ldval", sw_if.ld_val, 16'h9900);
    chk("sel01_up", 16'(sw_if.cnt_up), 16'h1);
    chk("sel01_en", 16'(sw_if.cnt_en), 16'h0);
    cyc(1);
    chk("sel01_ld_off", 16'(sw_if.cnt_ld), 16'h0);
    sel = 2'b11; load = 8'hA5;
    cyc(1);
    chk("sel11_ld", 16'(sw_if.cnt_ld), 16'h1);
    chk("sel11_ldval", sw_if.ld_val, 16'h9500);
    chk("sel11_up", 16'(sw_if.cnt_up), 16'h0);
    cyc(1);
    sel = 2'b10;
    cyc(1);
    chk("sel10_ld", 16'(sw_if.cnt_ld), 16'h1);
    chk("sel10_ldval", sw_if.ld_val, 16'h9999);
    chk("sel10_up", 16'(sw_if.cnt_up), 16'h0);

    // Count down to terminal: tick with term=1 is swallowed, FSM goes DONE
    cyc(1);
    press_p();
    cyc(2);
    chk("dn_idle", 16'(cstateDb), 16'h0);
    cyc(1);
    chk("dn_run", 16'(cstateDb), 16'h1);
    cyc(2);
    chk("dn_pre", 16'(sw_if.cnt_en), 16'h0);
    cyc(1);
    chk("dn_pre2", 16'(sw_if.cnt_en), 16'h0);
    sw_if.term = 1'b1;
    cyc(1);
    chk("term_no_en", 16'(sw_if.cnt_en), 16'h0);
    chk("done_state", 16'(cstateDb), 16'h3);
    press_p();
    cyc(4);
    chk("done_ignore_p", 16'(cstateDb), 16'h3);
    chk("done_no_en", 16'(sw_if.cnt_en), 16'h0);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    cyc(2);
    chk("clr_latency", 16'(cstateDb), 16'h3);
    cyc(1);
    chk("clr_state", 16'(cstateDb), 16'h0);
    chk("clr_ld", 16'(sw_if.cnt_ld), 16'h1);
    chk("clr_ldval", sw_if.ld_val, 16'h9999);
    sw_if.term = 1'b0;

    // Asynchronous reset between edges while running
    press_p();
    cyc(3);
    chk("run_again", 16'(cstateDb), 16'h1);
    cyc(1);
    #2 R = 1'b0;
    #1;
    chk("arst_state", 16'(cstateDb), 16'h0);
    chk("arst_en", 16'(sw_if.cnt_en), 16'h0);
    chk("arst_ld", 16'(sw_if.cnt_ld), 16'h0);
    chk("arst_up", 16'(sw_if.cnt_up), 16'h1);
    chk("arst_ldval", sw_if.ld_val, 16'h0000);
    @(negedge clk);
    R = 1'b1;
    cyc(1);
    chk("rel_ld", 16'(sw_if.cnt_ld), 16'h1);
    chk("rel_ldval", sw_if.ld_val, 16'h9999);

    // Simultaneous P and clr: clear wins, stay IDLE with a load
    P = 1'b1; clr = 1'b1;
    cyc(1);
    P = 1'b0; clr = 1'b0;
    cyc(3);
    chk("both_state", 16'(cstateDb), 16'h0);
    chk("both_ld", 16'(sw_if.cnt_ld), 16'h1);
    cyc(1);
    chk("both_ld_off", 16'(sw_if.cnt_ld), 16'h0);
    cyc(4);
    chk("both_idle", 16'(cstateDb), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
